packet_arbiter: RTL
===================

Name: packet_arbiter

Overview:
- Wormhole output-port arbiter for the router datapath; shares one output channel between NUM_PORTS input flit buffers.
- Picks a requester whose buffer front holds a head flit, using round-robin priority.
- Locks the grant for the packet's full flit count and pops the granted buffer one flit per accepted transfer.
- Releases the lock after the tail flit; sits between the input buffers / address counters and the output mux.

Parameters:
NUM_PORTS, 4, number of requesting input buffers (2..8)
ADD_WIDTH, 8, width of the packet flit-length field
SEL_W, $clog2(NUM_PORTS), width of the mux select (derived, not overridden)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req_i  input  NUM_PORTS  bit p set: buffer p front flit is a head flit
req_length_i  input  NUM_PORTS*ADD_WIDTH  packed per-port packet length in flits, head included; port p at bits [p*ADD_WIDTH +: ADD_WIDTH]
data_valid_i  input  NUM_PORTS  bit p set: buffer p front flit valid
out_ready_i  input  1  downstream accepts a flit this cycle
grant_o  output  NUM_PORTS  one-hot registered grant; all zero when idle
sel_o  output  SEL_W  index of granted port; drives the output mux
pop_o  output  NUM_PORTS  one-hot pop to the granted buffer on a transfer (combinational)
out_valid_o  output  1  flit presented downstream this cycle
remaining_o  output  ADD_WIDTH  flits left in the locked packet
busy_o  output  1  high in LOCKED

Behaviour:
- Reset (synchronous, active-high, any state or mid-packet):
  - state=IDLE; grant_o=0; sel_o=0; remaining_o=0; priority pointer=0.
  - pop_o=0 and out_valid_o=0 during the reset cycle.
- States:
  - IDLE: grant_o=0, busy_o=0.
  - LOCKED: grant_o=onehot(sel_o), busy_o=1.
- IDLE, any req_i bit set:
  - Winner = first set bit searching ptr, ptr+1, ... NUM_PORTS-1, then 0 .. ptr-1.
  - Next cycle: sel_o=winner, remaining_o=req_length_i[winner], state=LOCKED.
  - Grant latency is 1 cycle from req_i.
  - Length 0 is loaded as 1.
- IDLE, no request: state and pointer hold.
- LOCKED, transfer:
  - transfer = data_valid_i[sel_o] && out_ready_i.
  - pop_o[sel_o] = transfer; out_valid_o = data_valid_i[sel_o].
  - Same-cycle combinational path; first transfer can occur in the first LOCKED cycle.
- LOCKED, transfer with remaining_o>1: remaining_o decrements by 1.
- LOCKED, no transfer (stall): everything holds; req_i of other ports ignored while locked.
- LOCKED, transfer with remaining_o==1 (tail):
  - ptr = sel_o+1, wrapping from NUM_PORTS-1 to 0; remaining_o=0.
  - Next state IDLE, giving one bubble cycle before the next grant.
- req_i on the granted port during LOCKED is ignored. Body flits never re-arbitrate.
- Decrement never underflows: remaining_o==0 occurs only in IDLE.

Optional Feature:
- Macro: PKT_ARB_BACK_TO_BACK_EN.
- Defined:
  - On the tail-transfer cycle, arbitrate in the same cycle among req_i with bit sel_o masked off; search starts at sel_o+1.
  - If a winner exists: state stays LOCKED, sel_o=winner, remaining_o=that port's length. No bubble cycle.
  - If no winner: go to IDLE.
- Undefined: always return to IDLE after the tail (one bubble cycle).

Decomposition:
- Package knock_arb_pkg:
  - arb_state_t enum {IDLE, LOCKED}.
  - Default constants NUM_PORTS_DEF=4 and LEN_WIDTH_DEF=8.
  - Function onehot_to_idx.
- Sub-module rr_priority_picker: combinational.
  - Inputs: req vector, start pointer.
  - Outputs: found flag, winner index.
  - Instantiated once, reused for the back-to-back mask path.
- Registers use the team's existing register module with enable.

Test Plan:
- Reset then req_i=4'b0100, length[2]=3, data_valid always 1, out_ready=1 -> grant_o=0100 from cycle+1; pop_o[2] high 3 cycles; remaining_o 3,2,1; IDLE after; ptr=3.
- req_i=4'b1111 with all lengths=1, held for 8 packets -> grants 0,1,2,3,0,1,2,3 with one IDLE bubble between each (macro off).
- Locked on port 1, length 4, out_ready_i toggled 1,0,0,1,1,1 -> pop_o[1] only on ready cycles; remaining_o holds during stalls; tail on the 4th transfer.
- req_length_i[0]=0, req_i=0001 -> remaining_o=1; a single pop; back to IDLE.
- Reset asserted mid-packet (remaining_o=5) -> next cycle grant_o=0, remaining_o=0, ptr=0; req_i=0010 afterwards is granted normally.
- PKT_ARB_BACK_TO_BACK_EN defined, ports 0 and 2 requesting, length 2 each -> port 0 tail cycle is followed directly by grant_o=0100 with no IDLE cycle.

Source files
------------

// File: rtl/packet_arbiter_pkg.sv
// Shared types and defaults for the wormhole output-port arbiter.
// Pure declarations: no latency, no flow control.
package knock_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int NUM_PORTS_DEF = 4;
  localparam int LEN_WIDTH_DEF = 8;

  // OR-reduction of set-bit positions; exact for a one-hot (or zero) vector of up to 8 ports.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/packet_arbiter_if.sv
// Request/grant bundle between the input flit buffers, the arbiter and the output mux.
// Wires only: no latency; flow control is data_valid_i/out_ready_i per flit.
interface packet_arbiter_if
  import knock_arb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int ADD_WIDTH = LEN_WIDTH_DEF
);
  localparam int SEL_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]           req_i;
  logic [NUM_PORTS*ADD_WIDTH-1:0] req_length_i;
  logic [NUM_PORTS-1:0]           data_valid_i;
  logic                           out_ready_i;
  logic [NUM_PORTS-1:0]           grant_o;
  logic [SEL_W-1:0]               sel_o;
  logic [NUM_PORTS-1:0]           pop_o;
  logic                           out_valid_o;
  logic [ADD_WIDTH-1:0]           remaining_o;
  logic                           busy_o;

  modport slave (
    input  req_i, req_length_i, data_valid_i, out_ready_i,
    output grant_o, sel_o, pop_o, out_valid_o, remaining_o, busy_o
  );

  modport master (
    output req_i, req_length_i, data_valid_i, out_ready_i,
    input  grant_o, sel_o, pop_o, out_valid_o, remaining_o, busy_o
  );

endinterface

// File: rtl/packet_arbiter_picker.sv
// Round-robin picker: first set req bit at or after start_ptr, wrapping.
// Combinational, zero latency; no flow control.
module rr_priority_picker
  import knock_arb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  localparam int SEL_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [SEL_W-1:0]     start_ptr,
  output logic                 found,
  output logic [SEL_W-1:0]     winner
);

  logic [NUM_PORTS-1:0] win_oh;

  always_comb begin
    found  = 1'b0;
    win_oh = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      int j;
      j = (int'(start_ptr) + i) % NUM_PORTS;
      if (!found && req[j]) begin
        found     = 1'b1;
        win_oh[j] = 1'b1;
      end
    end
    winner = SEL_W'(onehot_to_idx(8'(win_oh)));
  end

endmodule

// File: rtl/packet_arbiter.sv
// Wormhole output arbiter: locks one input for a whole packet, round-robin between packets.
// Grant 1 cycle after req; pops same-cycle on data_valid && out_ready; stalls hold all state.
// PKT_ARB_BACK_TO_BACK_EN: re-arbitrate on the tail cycle, removing the idle bubble.
module packet_arbiter
  import knock_arb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int ADD_WIDTH = LEN_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  packet_arbiter_if.slave  arb
);

  localparam int SEL_W = $clog2(NUM_PORTS);

  arb_state_t            state_q, state_d;
  logic [SEL_W-1:0]      sel_q, ptr_q, sel_inc, pick_start, pick_idx;
  logic [ADD_WIDTH-1:0]  rem_q, pick_len, load_len;
  logic [NUM_PORTS-1:0]  sel_oh, pick_req;
  logic                  pick_found, xfer, tail, load;

  assign sel_oh  = NUM_PORTS'(1) << sel_q;
  assign sel_inc = (sel_q == SEL_W'(NUM_PORTS - 1)) ? '0 : sel_q + 1'b1;

  assign xfer = (state_q == LOCKED) && arb.data_valid_i[sel_q] && arb.out_ready_i;
  assign tail = xfer && (rem_q == ADD_WIDTH'(1));

`ifdef PKT_ARB_BACK_TO_BACK_EN
  // While locked the picker only matters on the tail cycle: the current owner is excluded.
  assign pick_req   = (state_q == LOCKED) ? (arb.req_i & ~sel_oh) : arb.req_i;
  assign pick_start = (state_q == LOCKED) ? sel_inc : ptr_q;
  assign load       = ((state_q == IDLE) || tail) && pick_found;
`else
  assign pick_req   = arb.req_i;
  assign pick_start = ptr_q;
  assign load       = (state_q == IDLE) && pick_found;
`endif

  rr_priority_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .req       (pick_req),
    .start_ptr (pick_start),
    .found     (pick_found),
    .winner    (pick_idx)
  );

  assign pick_len = arb.req_length_i[int'(pick_idx)*ADD_WIDTH +: ADD_WIDTH];
  // A zero length still carries its head flit.
  assign load_len = (pick_len == '0) ? ADD_WIDTH'(1) : pick_len;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (pick_found) state_d = LOCKED;
      LOCKED: if (tail) begin
`ifdef PKT_ARB_BACK_TO_BACK_EN
        state_d = pick_found ? LOCKED : IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= '0;
      ptr_q <= '0;
      rem_q <= '0;
    end else begin
      if (tail) ptr_q <= sel_inc;
      if (load) begin
        sel_q <= pick_idx;
        rem_q <= load_len;
      end else if (tail) begin
        rem_q <= '0;
      end else if (xfer) begin
        rem_q <= rem_q - 1'b1;
      end
    end
  end

  always_comb begin
    arb.grant_o     = '0;
    arb.pop_o       = '0;
    arb.out_valid_o = 1'b0;
    arb.busy_o      = 1'b0;
    if (state_q == LOCKED) begin
      arb.grant_o = sel_oh;
      arb.busy_o  = 1'b1;
      if (!reset) begin
        arb.out_valid_o = arb.data_valid_i[sel_q];
        if (xfer) arb.pop_o = sel_oh;
      end
    end
  end

  assign arb.sel_o       = sel_q;
  assign arb.remaining_o = rem_q;

endmodule
